// File: rtl/panel_pkg.sv
// panel_pkg: mode and state encodings shared by the front-panel channel mux
package panel_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;
    function automatic state_t decode_state(input logic enable, input logic mode);
        return !enable ? ST_BLANK : (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: modulo-PRESCALE dwell counter; tick flags the edge on which it wraps
module scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [CW-1:0] r_cnt;
    logic          w_tc;
    assign w_tc = (r_cnt == CW'(PRESCALE - 1));
    assign tick = run && w_tc;
    always_ff @(posedge clk) begin
        if (rst || clear)
            r_cnt <= '0;
        else if (run)
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/scan_mux_nto1.sv
// scan_mux_nto1: registered N-to-1 digit mux with manual select or timed auto-scan and blanking
module scan_mux_nto1
    import panel_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int W        = 4,
    parameter int PRESCALE = 1000,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] in_bus,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              enable,
    output logic [W-1:0]      out_data,
    output logic [N_CH-1:0]   out_onehot,
    output logic [SEL_W-1:0]  out_idx,
    output logic              tick
);
    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_idx, w_idx_nxt;
    logic [W-1:0]     r_data, w_chan;
    logic             r_tick, w_adv;
    scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (w_state_nxt == ST_SCAN),
        .clear (w_state_nxt == ST_MANUAL),
        .tick  (w_adv)
    );
    always_comb begin
        w_state_nxt = decode_state(enable, mode);
        w_idx_nxt   = (w_state_nxt == ST_MANUAL && 32'(sel) < N_CH) ? sel :
                      w_adv ? ((r_idx == SEL_W'(N_CH - 1)) ? '0 : r_idx + SEL_W'(1)) :
                      r_idx;
        w_chan      = in_bus[32'(w_idx_nxt) * W +: W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_data  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= (w_state_nxt == ST_BLANK) ? '0 : w_chan;
            r_tick  <= w_adv;
        end
    end
    // one-hot is rebuilt from the registered index so it can never disagree with out_idx
    assign out_onehot = (r_state == ST_BLANK) ? '0 : N_CH'(1) << r_idx;
    assign out_data   = r_data;
    assign out_idx    = r_idx;
    assign tick       = r_tick;
endmodule

// File: tb/tb_scan_mux_nto1.sv
// tb_scan_mux_nto1: scoreboard bench driving a 4-channel/PRESCALE=4 and a 3-channel/PRESCALE=1 mux in lockstep
module tb_scan_mux_nto1;
    typedef struct {
        logic [3:0] data;
        logic [3:0] oh;
        logic [1:0] idx;
        logic       tick;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst, enable, mode;
    logic [1:0]  sel;
    logic [15:0] bus;
    logic [3:0]  a_data, b_data;
    logic [3:0]  a_oh;
    logic [2:0]  b_oh;
    logic [1:0]  a_idx, b_idx;
    logic        a_tick, b_tick;
    exp_t        qa[$], qb[$];
    exp_t        ea, eb;
    int          m_idx[2] = '{0, 0};
    int          m_cnt[2] = '{0, 0};
    int          n_ch[2]  = '{4, 3};
    int          pre[2]   = '{4, 1};
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    scan_mux_nto1 #(.N_CH(4), .W(4), .PRESCALE(4)) dut_a (
        .clk(clk), .rst(rst), .in_bus(bus), .mode(mode), .sel(sel), .enable(enable),
        .out_data(a_data), .out_onehot(a_oh), .out_idx(a_idx), .tick(a_tick)
    );
    scan_mux_nto1 #(.N_CH(3), .W(4), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .in_bus(bus[11:0]), .mode(mode), .sel(sel), .enable(enable),
        .out_data(b_data), .out_onehot(b_oh), .out_idx(b_idx), .tick(b_tick)
    );
    task automatic predict(input int k, output exp_t x);
        logic tk;
        tk = 1'b0;
        if (rst) begin
            m_idx[k] = 0;
            m_cnt[k] = 0;
            x = '{4'd0, 4'd0, 2'd0, 1'b0};
        end else if (!enable) begin
            x = '{4'd0, 4'd0, 2'(m_idx[k]), 1'b0};
        end else begin
            if (!mode) begin
                m_cnt[k] = 0;
                if (int'(sel) < n_ch[k]) m_idx[k] = int'(sel);
            end else if (m_cnt[k] == pre[k] - 1) begin
                m_cnt[k] = 0;
                tk = 1'b1;
                m_idx[k] = (m_idx[k] + 1) % n_ch[k];
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            x.data = 4'(bus >> (4 * m_idx[k]));
            x.oh   = 4'(1 << m_idx[k]);
            x.idx  = 2'(m_idx[k]);
            x.tick = tk;
        end
    endtask
    task automatic step(input logic r, input logic e, input logic m, input logic [1:0] s, input logic [15:0] b);
        exp_t x;
        rst = r; enable = e; mode = m; sel = s; bus = b;
        predict(0, x);
        qa.push_back(x);
        predict(1, x);
        qb.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask
    always @(posedge clk) begin
        #2;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_data", a_data, ea.data);
            chk("a_onehot", a_oh, ea.oh);
            chk("a_idx", {2'b0, a_idx}, {2'b0, ea.idx});
            chk("a_tick", {3'b0, a_tick}, {3'b0, ea.tick});
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_data", b_data, eb.data);
            chk("b_onehot", {1'b0, b_oh}, eb.oh);
            chk("b_idx", {2'b0, b_idx}, {2'b0, eb.idx});
            chk("b_tick", {3'b0, b_tick}, {3'b0, eb.tick});
        end
    end
    initial begin
        repeat (2) step(1, 1, 1, 2'd2, 16'h4321);
        repeat (2) step(0, 0, 0, 2'd2, 16'h4321);
        step(0, 1, 0, 2'd2, 16'h4321);
        step(0, 1, 0, 2'd1, 16'h4321);
        step(0, 1, 0, 2'd3, 16'h4321);
        step(0, 1, 0, 2'd3, 16'h8765);
        step(0, 1, 0, 2'd0, 16'h4321);
        repeat (17) step(0, 1, 1, 2'd0, 16'h4321);
        repeat (3) step(0, 1, 1, 2'd0, 16'hABCD);
        repeat (2) step(0, 1, 1, 2'd3, 16'h4321);
        repeat (5) step(0, 0, 1, 2'd1, 16'h9999);
        step(0, 0, 0, 2'd3, 16'h9999);
        repeat (6) step(0, 1, 1, 2'd0, 16'h4321);
        step(0, 1, 0, 2'd1, 16'h4321);
        repeat (6) step(0, 1, 1, 2'd1, 16'h4321);
        step(1, 1, 1, 2'd2, 16'h4321);
        repeat (7) step(0, 1, 1, 2'd2, 16'h4321);
        repeat (3) @(posedge clk);
        #3;
        n_chk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
